// File: rtl/button_pkg.sv
// Shared types and defaults for the button event block.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } button_state_t;

    localparam int BTN_LONG_COUNTS_DEFAULT   = 32'd50_000_000;
    localparam int BTN_REPEAT_COUNTS_DEFAULT = 32'd12_500_000;

    // Hold-counter width: enough for the largest terminal count in use, plus one bit.
    function automatic int btn_cnt_width(input int long_counts,
                                         input int repeat_counts,
                                         input bit repeat_en);
        int max_v;
        if (repeat_en && (repeat_counts > long_counts)) begin
            max_v = repeat_counts;
        end else begin
            max_v = long_counts;
        end
        return $clog2(max_v) + 32'd1;
    endfunction

endpackage

// File: rtl/button_events_edge_detect.sv
// Registered rise/fall detector for a level already synchronous to clk.
// The event flags are registered, so a level change reaches a downstream
// registered consumer two edges after it is first sampled.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic prev_r;
    logic rise_r;
    logic fall_r;

    // Track the previous level and register the edge flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            prev_r <= level;
            rise_r <= level & ~prev_r;
            fall_r <= ~level & prev_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/button_events.sv
// Button level to event pulses: press, release, click, long press, repeat.
// Optional auto-repeat is built when BUTTON_EVENTS_REPEAT_EN is defined;
// otherwise repeat_pulse is tied low and the LONG state holds the counter at 0.
module button_events
    import button_pkg::*;
#(
    parameter int LONG_COUNTS   = BTN_LONG_COUNTS_DEFAULT,
    parameter int REPEAT_COUNTS = BTN_REPEAT_COUNTS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

`ifdef BUTTON_EVENTS_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    localparam int              CW        = btn_cnt_width(LONG_COUNTS, REPEAT_COUNTS, REPEAT_EN);
    localparam logic [CW-1:0]   LONG_LAST = CW'(LONG_COUNTS - 32'd1);
`ifdef BUTTON_EVENTS_REPEAT_EN
    localparam logic [CW-1:0]   REPEAT_LAST = CW'(REPEAT_COUNTS - 32'd1);
`endif

    button_state_t  state_r;
    button_state_t  state_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_s;
    logic           rise_s;
    logic           fall_s;

    logic press_s, release_s, click_s, long_s, repeat_s, held_s;
    logic press_r, release_r, click_r, long_r, repeat_r, held_r;

    edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .level (level),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // State and hold-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state and counter; a fall always takes priority over terminal counts.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                cnt_s = '0;
                if (rise_s) begin
                    state_s = HELD;
                end else begin
                    state_s = IDLE;
                end
            end
            HELD: begin
                if (fall_s) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else if (cnt_r == LONG_LAST) begin
                    state_s = LONG;
                    cnt_s   = '0;
                end else begin
                    state_s = HELD;
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            LONG: begin
                if (fall_s) begin
                    state_s = IDLE;
                    cnt_s   = '0;
`ifdef BUTTON_EVENTS_REPEAT_EN
                end else if (cnt_r == REPEAT_LAST) begin
                    state_s = LONG;
                    cnt_s   = '0;
                end else begin
                    state_s = LONG;
                    cnt_s   = cnt_r + CW'(1);
                end
`else
                end else begin
                    state_s = LONG;
                    cnt_s   = '0;
                end
`endif
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Pulse decode for the coming cycle; click only on releases before the press went long.
    always_comb begin
        press_s   = 1'b0;
        release_s = 1'b0;
        click_s   = 1'b0;
        long_s    = 1'b0;
        repeat_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    press_s = 1'b1;
                end else begin
                    press_s = 1'b0;
                end
            end
            HELD: begin
                if (fall_s) begin
                    release_s = 1'b1;
                    click_s   = 1'b1;
                end else if (cnt_r == LONG_LAST) begin
                    long_s = 1'b1;
                end else begin
                    long_s = 1'b0;
                end
            end
            LONG: begin
                if (fall_s) begin
                    release_s = 1'b1;
`ifdef BUTTON_EVENTS_REPEAT_EN
                end else if (cnt_r == REPEAT_LAST) begin
                    repeat_s = 1'b1;
`endif
                end else begin
                    repeat_s = 1'b0;
                end
            end
            default: begin
                press_s = 1'b0;
            end
        endcase
        held_s = (state_s != IDLE);
    end

    // Output register: every event leaves the block from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            click_r   <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
            held_r    <= 1'b0;
        end else begin
            press_r   <= press_s;
            release_r <= release_s;
            click_r   <= click_s;
            long_r    <= long_s;
            repeat_r  <= repeat_s;
            held_r    <= held_s;
        end
    end

    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign click_pulse   = click_r;
    assign long_pulse    = long_r;
    assign repeat_pulse  = repeat_r;
    assign held          = held_r;

endmodule

// File: tb/tb_button_events.sv
// Self-checking bench for button_events (LONG_COUNTS=8, REPEAT_COUNTS=3).
// Output vector layout: {held, repeat, long, click, release, press}.
module tb_button_events;

    localparam int L = 8;
    localparam int R = 3;
`ifdef BUTTON_EVENTS_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    localparam logic [5:0] PRS = 6'b000001;
    localparam logic [5:0] REL = 6'b000010;
    localparam logic [5:0] CLK = 6'b000100;
    localparam logic [5:0] HLD = 6'b100000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic level = 1'b0;
    logic press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held;

    button_events #(.LONG_COUNTS(L), .REPEAT_COUNTS(R)) dut (
        .clk           (clk),
        .reset         (reset),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .click_pulse   (click_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lvl;
        logic       rst;
        logic [5:0] exp;
    } vec_t;

    vec_t vtbl[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: press age counted in cycles, events from the two-edge delayed level.
    bit m_pressed = 1'b0;
    bit m_h1 = 1'b0;
    bit m_h2 = 1'b0;
    int m_age = 0;
    logic [5:0] prev_act = 6'b0;

    task automatic add(input logic lvl, input logic rst, input logic [5:0] exp);
        vec_t v;
        v.lvl = lvl; v.rst = rst; v.exp = exp;
        vtbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic lvl, input logic rst, output logic [5:0] exp);
        exp = 6'b0;
        if (rst) begin
            m_pressed = 1'b0; m_age = 0; m_h1 = 1'b0; m_h2 = 1'b0;
        end else begin
            if (!m_pressed) begin
                if (m_h1 && !m_h2) begin
                    m_pressed = 1'b1; m_age = 0; exp[0] = 1'b1;
                end
            end else if (!m_h1) begin
                exp[1] = 1'b1;
                exp[2] = (m_age < L);
                m_pressed = 1'b0;
            end else begin
                m_age++;
                if (m_age == L) exp[3] = 1'b1;
                else if (REP_EN && m_age > L && ((m_age - L) % R) == 0) exp[4] = 1'b1;
            end
            m_h2 = m_h1;
            m_h1 = lvl;
            exp[5] = m_pressed;
        end
    endtask

    function automatic logic legal(input logic [5:0] a);
        int hot;
        hot = int'(a[0]) + int'(a[3]) + int'(a[4]);
        return (hot <= 1) && !(a[1] && (a[0] || a[3] || a[4])) && !(a[2] && !a[1]);
    endfunction

    task automatic step(input logic lvl, input logic rst, output logic [5:0] act);
        logic [5:0] exp;
        level = lvl;
        reset = rst;
        @(posedge clk);
        model_edge(lvl, rst, exp);
        #1;
        cyc++;
        act = {held, repeat_pulse, long_pulse, click_pulse, release_pulse, press_pulse};
        check("model", act, exp);
        check("pulse_width", {5'b0, (act[4:0] & prev_act[4:0]) == 5'b0}, 6'b1);
        check("exclusive", {5'b0, legal(act)}, 6'b1);
        prev_act = act;
    endtask

    initial begin
        logic [5:0] act;
        int press_c, long_c, rel_c, rst_c;
        logic rel_click, saw_rel;
        int rep_q[$];
        logic lv;

        // Reset, idle, then a 4-cycle short press.
        add(1'b0, 1'b1, 6'b0);
        add(1'b0, 1'b0, 6'b0);
        add(1'b0, 1'b0, 6'b0);
        add(1'b1, 1'b0, 6'b0);
        add(1'b1, 1'b0, PRS | HLD);
        add(1'b1, 1'b0, HLD);
        add(1'b1, 1'b0, HLD);
        add(1'b0, 1'b0, HLD);
        add(1'b0, 1'b0, REL | CLK);
        add(1'b0, 1'b0, 6'b0);
        // Single-cycle press.
        add(1'b1, 1'b0, 6'b0);
        add(1'b0, 1'b0, PRS | HLD);
        add(1'b0, 1'b0, REL | CLK);
        add(1'b0, 1'b0, 6'b0);
        // Fall detected on the cycle long_pulse would fire: click wins.
        add(1'b1, 1'b0, 6'b0);
        add(1'b1, 1'b0, PRS | HLD);
        for (int i = 0; i < 6; i++) add(1'b1, 1'b0, HLD);
        add(1'b0, 1'b0, HLD);
        add(1'b0, 1'b0, REL | CLK);
        add(1'b0, 1'b0, 6'b0);

        for (int i = 0; i < vtbl.size(); i++) begin
            step(vtbl[i].lvl, vtbl[i].rst, act);
            check($sformatf("vec%0d", i), act, vtbl[i].exp);
        end

        // Long hold of 21 cycles.
        press_c = -100; long_c = -100; rel_c = -100; rel_click = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step((i < 21) ? 1'b1 : 1'b0, 1'b0, act);
            if (act[0]) press_c = cyc;
            if (act[3]) long_c = cyc;
            if (act[4]) rep_q.push_back(cyc - long_c);
            if (act[1]) begin rel_c = cyc; rel_click = act[2]; end
        end
        check_int("long_delay", long_c - press_c, L);
        check_int("release_delay", rel_c - press_c, 21);
        check_int("long_release_click", int'(rel_click), 0);
        check_int("repeat_count", rep_q.size(), REP_EN ? 4 : 0);
        for (int k = 0; k < rep_q.size(); k++) check_int("repeat_offset", rep_q[k], (k + 1) * R);

        // Reset mid-hold with level still high.
        step(1'b1, 1'b0, act);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, act);
        step(1'b1, 1'b1, act);
        rst_c = cyc;
        check("reset_outs", act, 6'b0);
        press_c = -100; long_c = -100; saw_rel = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, act);
            if (act[0]) press_c = cyc;
            if (act[3]) long_c = cyc;
            if (act[1] || act[2]) saw_rel = 1'b1;
        end
        check_int("reset_press_delay", press_c - rst_c, 2);
        check_int("reset_long_delay", long_c - press_c, L);
        check_int("reset_no_release", int'(saw_rel), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, act);

        // Randomized level toggles with occasional resets.
        lv = 1'b0;
        for (int b = 0; b < 80; b++) begin
            int len;
            logic r;
            lv  = ~lv;
            len = $urandom_range(1, 14);
            r   = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < len; k++) step(lv, r && (k == 0), act);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
